// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM read-port arbiter.
// Imported by the interface, the round-robin picker and the top.
package ram_arb_pkg;

   localparam int N_REQ_DEF      = 4;
   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 32;
   localparam int RAM_LAT_DEF    = 1;
   localparam int STARVE_MAX_DEF = 15;
   localparam int MAX_REQ        = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

   // Rotate the low w bits of v up by n; bits at w and above pass through.
   function automatic logic [MAX_REQ-1:0] rotl(
      input logic [MAX_REQ-1:0] v,
      input int                 n,
      input int                 w
   );
      logic [MAX_REQ-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < w) r[(i + n) % w] = v[i];
         else       r[i] = v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_read_arbiter_if.sv
// Requester-side bus of the RAM read arbiter.
// Requesters use master, the arbiter uses slave.
interface ram_read_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] raddr;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]       rdata;

   modport master (
      output req,
      output raddr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  raddr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/ram_read_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester above last,
// wrapping around.
module rr_picker
   import ram_arb_pkg::*;
#(
   parameter int N     = N_REQ_DEF,
   parameter int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     pick,
   output logic             valid
);

   logic [MAX_REQ-1:0] ext;
   logic [MAX_REQ-1:0] rot;
   logic [MAX_REQ-1:0] first;
   logic [MAX_REQ-1:0] back;
   logic               found;
   int                 sh;

   // Rotate so that port last+1 sits at bit 0, take the lowest set bit,
   // then rotate the one-hot result back.
   always_comb begin
      ext        = '0;
      ext[N-1:0] = req;
      sh         = (int'(last) + 1) % N;
      rot        = rotl(ext, N - sh, N);
      first      = '0;
      found      = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (rot[i] && !found) begin
            first[i] = 1'b1;
            found    = 1'b1;
         end
      end
      back = rotl(first, sh, N);
   end

   assign pick  = back[N-1:0];
   assign valid = |back;

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares one RAM read port between N_REQ requesters and returns
// one-hot tagged read data after the RAM latency.
module ram_read_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ      = N_REQ_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RAM_LAT    = RAM_LAT_DEF,
   parameter bit PRIO0      = 1'b1,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic               clk,
   input  logic               reset,
   ram_read_arbiter_if.slave  bus,
   output logic [ADDR_W-1:0]  ram_raddr,
   input  logic [DATA_W-1:0]  ram_dout,
   output logic               busy
);

   localparam int IDX_W = clog2(N_REQ);
   localparam int SC_W  = clog2(STARVE_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

   logic [N_REQ-1:0] rr_mask;
   logic [N_REQ-1:0] rr_pick;
   logic             rr_valid;
   logic             rr_grant;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_last;
   logic [SC_W-1:0]  starve_cnt;
   logic             starve_flag;
   logic [N_REQ-1:0] pipe [RAM_LAT];

   always_comb begin
      rr_mask = bus.req;
      if (PRIO0) rr_mask[0] = 1'b0;
   end

   rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req   (rr_mask),
      .last  (rr_last),
      .pick  (rr_pick),
      .valid (rr_valid)
   );

   assign starve_flag = PRIO0 && (starve_cnt == SC_MAX);

   always_comb begin
      gnt = '0;
      priority case (1'b1)
         reset:                     gnt = '0;
         (starve_flag && rr_valid): gnt = rr_pick;
         (PRIO0 && bus.req[0]):     gnt = N_REQ'(1);
         default:                   gnt = rr_pick;
      endcase
   end

   always_comb begin
      gnt_idx   = '0;
      ram_raddr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx   = IDX_W'(i);
            ram_raddr = bus.raddr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign rr_grant = |(gnt & rr_mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_last <= LAST_RST;
      else if (rr_grant) rr_last <= gnt_idx;
   end

   // Counts port-0 wins while the ring waits; saturates, never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (!PRIO0 || rr_grant || !rr_valid)
         starve_cnt <= '0;
      else if (gnt[0] && starve_cnt != SC_MAX)
         starve_cnt <= starve_cnt + SC_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < RAM_LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= gnt;
         for (int k = 1; k < RAM_LAT; k++) pipe[k] <= pipe[k-1];
      end
   end

   always_comb begin
      busy = |gnt;
      for (int k = 0; k < RAM_LAT; k++) busy = busy | (|pipe[k]);
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = pipe[RAM_LAT-1];
   assign bus.rdata  = ram_dout;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench for ram_read_arbiter: one instance with RAM_LAT=1,
// one with RAM_LAT=3, each behind a simple RAM model.
module tb_ram_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ram_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) b1 ();
   ram_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) b3 ();

   logic [AW-1:0] ram_raddr1, ram_raddr3;
   logic [DW-1:0] ram_dout1, ram_dout3, d3a, d3b;
   logic          busy1, busy3;

   int checks   = 0;
   int failures = 0;

   ram_read_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW),
      .RAM_LAT(1), .PRIO0(1'b1), .STARVE_MAX(15)
   ) u1 (
      .clk(clk), .reset(reset), .bus(b1),
      .ram_raddr(ram_raddr1), .ram_dout(ram_dout1), .busy(busy1)
   );

   ram_read_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW),
      .RAM_LAT(3), .PRIO0(1'b1), .STARVE_MAX(15)
   ) u3 (
      .clk(clk), .reset(reset), .bus(b3),
      .ram_raddr(ram_raddr3), .ram_dout(ram_dout3), .busy(busy3)
   );

   // RAM contents: word at address a reads as 0xDEAD00aa.
   always_ff @(posedge clk) begin
      ram_dout1 <= {24'hDEAD00, ram_raddr1};
      d3a       <= {24'hDEAD00, ram_raddr3};
      d3b       <= d3a;
      ram_dout3 <= d3b;
   end

   task automatic do_reset();
      reset    = 1'b1;
      b1.req   = '0;
      b3.req   = '0;
      b1.raddr = '0;
      b3.raddr = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      b1.req   = 4'hF;
      b1.raddr = 32'h44332211;
      b3.req   = 4'hF;
      @(negedge clk);
      checks++;
      if (b1.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL reset_gnt got=%b exp=0000", b1.gnt);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      b1.req = '0;
      b3.req = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({b1.gnt, b1.rvalid, busy1, ram_raddr1} !== '0) begin
            failures++;
            $display("FAIL reset_idle1 c=%0d gnt=%b rv=%b busy=%b ra=%h exp=0",
                     c, b1.gnt, b1.rvalid, busy1, ram_raddr1);
         end
         checks++;
         if ({b3.gnt, b3.rvalid, busy3, ram_raddr3} !== '0) begin
            failures++;
            $display("FAIL reset_idle3 c=%0d gnt=%b rv=%b busy=%b ra=%h exp=0",
                     c, b3.gnt, b3.rvalid, busy3, ram_raddr3);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_single();
      do_reset();
      b1.req   = 4'b0100;
      b1.raddr = 32'h7A13_5501;
      @(negedge clk);
      checks++;
      if (b1.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL single_gnt got=%b exp=0100", b1.gnt);
      end
      checks++;
      if (ram_raddr1 !== 8'h13) begin
         failures++;
         $display("FAIL single_raddr got=%h exp=13", ram_raddr1);
      end
      @(posedge clk);
      #1;
      b1.req = '0;
      @(negedge clk);
      checks++;
      if (b1.rvalid !== 4'b0100) begin
         failures++;
         $display("FAIL single_rvalid got=%b exp=0100", b1.rvalid);
      end
      checks++;
      if (b1.rdata !== 32'hDEAD0013) begin
         failures++;
         $display("FAIL single_rdata got=%h exp=DEAD0013", b1.rdata);
      end
      checks++;
      if (busy1 !== 1'b1) begin
         failures++;
         $display("FAIL single_busy got=%b exp=1", busy1);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({b1.rvalid, busy1} !== 5'b0) begin
         failures++;
         $display("FAIL single_idle rv=%b busy=%b exp=0", b1.rvalid, busy1);
      end
   endtask

   task automatic test_single_requester();
      logic [3:0] rq [2];
      rq = '{4'b0001, 4'b0100};
      for (int p = 0; p < 2; p++) begin
         do_reset();
         b1.req = rq[p];
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (b1.gnt !== rq[p]) begin
               failures++;
               $display("FAIL lone_req p=%0d k=%0d got=%b exp=%b",
                        p, k, b1.gnt, rq[p]);
            end
            @(posedge clk);
            #1;
         end
      end
      b1.req = '0;
   endtask

   task automatic test_round_robin();
      logic [3:0]  eg [6];
      logic [7:0]  ea [6];
      logic [3:0]  prev_g;
      logic [7:0]  prev_a;
      eg = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
      ea = '{8'h21, 8'h22, 8'h23, 8'h21, 8'h22, 8'h23};
      do_reset();
      b1.raddr = 32'h2322_2120;
      b1.req   = 4'b1110;
      prev_g   = '0;
      prev_a   = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (b1.gnt !== eg[k]) begin
            failures++;
            $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, b1.gnt, eg[k]);
         end
         checks++;
         if (ram_raddr1 !== ea[k]) begin
            failures++;
            $display("FAIL rr_raddr k=%0d got=%h exp=%h", k, ram_raddr1, ea[k]);
         end
         checks++;
         if (b1.rvalid !== prev_g) begin
            failures++;
            $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, b1.rvalid, prev_g);
         end
         if (k > 0) begin
            checks++;
            if (b1.rdata !== {24'hDEAD00, prev_a}) begin
               failures++;
               $display("FAIL rr_rdata k=%0d got=%h exp=DEAD00%h",
                        k, b1.rdata, prev_a);
            end
         end
         prev_g = eg[k];
         prev_a = ea[k];
         @(posedge clk);
         #1;
      end
      b1.req = '0;
      @(negedge clk);
      checks++;
      if (b1.rvalid !== 4'b1000 || b1.rdata !== 32'hDEAD0023) begin
         failures++;
         $display("FAIL rr_last_ret rv=%b rd=%h exp=1000/DEAD0023",
                  b1.rvalid, b1.rdata);
      end
   endtask

   task automatic test_starvation();
      logic [3:0] exp_g;
      do_reset();
      b1.raddr = 32'h4300_0040;
      b1.req   = 4'b1001;
      for (int k = 0; k < 32; k++) begin
         exp_g = ((k % 16) == 15) ? 4'b1000 : 4'b0001;
         @(negedge clk);
         checks++;
         if (b1.gnt !== exp_g) begin
            failures++;
            $display("FAIL starve_gnt k=%0d got=%b exp=%b", k, b1.gnt, exp_g);
         end
         @(posedge clk);
         #1;
      end
      b1.req = '0;
   endtask

   task automatic test_reset_in_flight();
      do_reset();
      b1.raddr = 32'h0032_3100;
      b1.req   = 4'b0010;
      @(negedge clk);
      checks++;
      if (b1.gnt !== 4'b0010) begin
         failures++;
         $display("FAIL rif_gnt got=%b exp=0010", b1.gnt);
      end
      @(posedge clk);
      #1;
      reset  = 1'b1;
      b1.req = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({b1.rvalid, busy1} !== 5'b0) begin
            failures++;
            $display("FAIL rif_flush c=%0d rv=%b busy=%b exp=0",
                     c, b1.rvalid, busy1);
         end
         @(posedge clk);
         #1;
      end
      reset  = 1'b0;
      b1.req = 4'b0110;
      @(negedge clk);
      checks++;
      if (b1.gnt !== 4'b0010 || b1.rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL rif_regnt gnt=%b rv=%b exp=0010/0000",
                  b1.gnt, b1.rvalid);
      end
      @(posedge clk);
      #1;
      b1.req = 4'b0100;
      @(negedge clk);
      checks++;
      if (b1.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL rif_next_gnt got=%b exp=0100", b1.gnt);
      end
      checks++;
      if (b1.rvalid !== 4'b0010 || b1.rdata !== 32'hDEAD0031) begin
         failures++;
         $display("FAIL rif_ret rv=%b rd=%h exp=0010/DEAD0031",
                  b1.rvalid, b1.rdata);
      end
      @(posedge clk);
      #1;
      b1.req = '0;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  rq [7];
      logic [3:0]  ev [7];
      logic [31:0] ed [7];
      rq = '{4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
      ev = '{4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b1000, 4'b0};
      ed = '{32'h0, 32'h0, 32'h0, 32'hDEAD0051, 32'hDEAD0062,
             32'hDEAD0073, 32'h0};
      do_reset();
      b3.raddr = 32'h7362_5100;
      for (int k = 0; k < 7; k++) begin
         b3.req = rq[k];
         @(negedge clk);
         checks++;
         if (b3.gnt !== rq[k]) begin
            failures++;
            $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, b3.gnt, rq[k]);
         end
         checks++;
         if (b3.rvalid !== ev[k]) begin
            failures++;
            $display("FAIL b2b_rvalid k=%0d got=%b exp=%b", k, b3.rvalid, ev[k]);
         end
         if (ev[k] != 4'b0) begin
            checks++;
            if (b3.rdata !== ed[k]) begin
               failures++;
               $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, b3.rdata, ed[k]);
            end
         end
         checks++;
         if (busy3 !== (k < 6)) begin
            failures++;
            $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy3, (k < 6));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_single_requester();
      test_round_robin();
      test_starvation();
      test_reset_in_flight();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
